// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-deep holding register and valid/ready handoff.
// Start is detected in IDLE; the line is sampled mid-bit after a half-bit offset.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   IDLE      | line idle, waiting for rxs low
//   START     | half-bit wait, confirm start bit
//   DATA      | sample 8 data bits, LSB first
//   STOP      | sample stop bit
//   WAIT_HIGH | bad stop bit, wait for line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       CLK_125MHZ_I,
    input  logic       reset,
    input  logic       RXD_I,
    output logic [7:0] DATA_O,
    output logic       VALID_O,
    input  logic       READY_I,
    output logic       FRAME_ERR_O,
    output logic       OVERRUN_O,
    output logic       BUSY_O
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, rxs_q;
    logic [1:0]    settle_q, settle_d;
    logic          armed_q, armed_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;

    always_ff @(posedge CLK_125MHZ_I) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            sync1_q   <= 1'b1;
            rxs_q     <= 1'b1;
            settle_q  <= '0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            sync1_q   <= RXD_I;
            rxs_q     <= sync1_q;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        // After reset the synchronizer reads high until real line data reaches it;
        // only a genuinely high line may arm start detection, so a frame cut by
        // reset cannot be mistaken for a new start bit.
        armed_d   = armed_q | ((settle_q == 2'd2) & rxs_q);

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (armed_q && !rxs_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (valid_q && READY_I) valid_d = 1'b0;
        if (done_q) begin
            if (valid_q && !READY_I) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    assign DATA_O      = data_q;
    assign VALID_O     = valid_q;
    assign FRAME_ERR_O = ferr_q;
    assign OVERRUN_O   = ovr_q;
    assign BUSY_O      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit; a monitor records handoffs
// and pulses, and the main sequence compares them against hand-computed values.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       rdy;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ferr_o;
    logic       ovr_o;
    logic       busy_o;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK_125MHZ_I (clk),
        .reset        (rst),
        .RXD_I        (rxd),
        .DATA_O       (data_o),
        .VALID_O      (valid_o),
        .READY_I      (rdy),
        .FRAME_ERR_O  (ferr_o),
        .OVERRUN_O    (ovr_o),
        .BUSY_O       (busy_o)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         valid_rise_cyc = -1;
    int         valid_hi = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         both_cnt = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] rxq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Samples 3 ns after the edge, after stimulus (2 ns) has settled.
    always @(posedge clk) begin
        #3;
        if (valid_o && !valid_prev) valid_rise_cyc = cyc;
        valid_prev = valid_o;
        if (valid_o) valid_hi++;
        if (valid_o && rdy) rxq.push_back(data_o);
        if (ferr_o) ferr_cnt++;
        if (ovr_o) ovr_cnt++;
        if (ferr_o && ovr_o) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        valid_rise_cyc = -1;
        valid_hi = 0;
        ferr_cnt = 0;
        ovr_cnt = 0;
        rxq.delete();
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rxq.size()) ? {24'd0, rxq[i]} : 32'hFFFF_FFFF;
    endfunction

    // Entered 2 ns after an edge; leaves the line high 2 ns after the final edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_b,
                              input int stop_bits, input int rst_bit);
        rxd = 1'b0;
        fall_cyc = cyc;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == rst_bit) begin
                hold(3);
                rst = 1'b1;
                hold(2);
                chk("midrst_data", {24'd0, data_o}, 32'h00);
                chk("midrst_valid", {31'd0, valid_o}, 0);
                chk("midrst_ferr", {31'd0, ferr_o}, 0);
                chk("midrst_ovr", {31'd0, ovr_o}, 0);
                chk("midrst_busy", {31'd0, busy_o}, 0);
                rst = 1'b0;
                hold(CPB - 5);
            end else begin
                hold(CPB);
            end
        end
        rxd = stop_b;
        hold(CPB * stop_bits);
        rxd = 1'b1;
    endtask

    int a5_fall;

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        rdy = 1'b1;
        hold(3);
        chk("rst_data", {24'd0, data_o}, 32'h00);
        chk("rst_valid", {31'd0, valid_o}, 0);
        chk("rst_ferr", {31'd0, ferr_o}, 0);
        chk("rst_ovr", {31'd0, ovr_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        rst = 1'b0;
        hold(12);

        // Single good frame, consumer ready
        clear_stats();
        send_frame(8'hA5, 1'b1, 1, -1);
        a5_fall = fall_cyc;
        hold(4);
        chk("a5_count", rxq.size(), 1);
        chk("a5_data", rx_at(0), 32'hA5);
        chk("a5_latency", valid_rise_cyc - a5_fall, 2 + CPB / 2 + 9 * CPB + 2);
        chk("a5_valid_cycles", valid_hi, 1);
        chk("a5_ferr", ferr_cnt, 0);
        chk("a5_ovr", ovr_cnt, 0);

        // Bad stop bit held low, then recovery
        clear_stats();
        send_frame(8'h3C, 1'b0, 20, -1);
        chk("fe_busy_low", {31'd0, busy_o}, 1);
        hold(4);
        chk("fe_busy_after", {31'd0, busy_o}, 0);
        chk("fe_ferr", ferr_cnt, 1);
        chk("fe_valid_cycles", valid_hi, 0);
        hold(4);
        send_frame(8'h55, 1'b1, 1, -1);
        hold(4);
        chk("fe_next_count", rxq.size(), 1);
        chk("fe_next_data", rx_at(0), 32'h55);
        chk("fe_next_ferr", ferr_cnt, 1);

        // Overrun with consumer stalled
        clear_stats();
        rdy = 1'b0;
        send_frame(8'h11, 1'b1, 1, -1);
        hold(4);
        send_frame(8'h22, 1'b1, 1, -1);
        hold(2);
        chk("ovr_valid", {31'd0, valid_o}, 1);
        chk("ovr_data", {24'd0, data_o}, 32'h11);
        chk("ovr_pulse", ovr_cnt, 1);
        chk("ovr_ferr", ferr_cnt, 0);
        rdy = 1'b1;
        hold(2);
        chk("ovr_drain_count", rxq.size(), 1);
        chk("ovr_drain_data", rx_at(0), 32'h11);
        chk("ovr_drain_valid", {31'd0, valid_o}, 0);

        // Short glitch on the line
        clear_stats();
        rxd = 1'b0;
        hold(3);
        rxd = 1'b1;
        hold(20);
        chk("gl_count", rxq.size(), 0);
        chk("gl_valid_cycles", valid_hi, 0);
        chk("gl_ferr", ferr_cnt, 0);
        chk("gl_ovr", ovr_cnt, 0);
        chk("gl_busy", {31'd0, busy_o}, 0);

        // Back-to-back frames, no idle gap
        clear_stats();
        send_frame(8'h00, 1'b1, 1, -1);
        send_frame(8'hFF, 1'b1, 1, -1);
        hold(4);
        chk("b2b_count", rxq.size(), 2);
        chk("b2b_first", rx_at(0), 32'h00);
        chk("b2b_second", rx_at(1), 32'hFF);
        chk("b2b_ferr", ferr_cnt, 0);

        // Reset during data bit 4, then a clean frame
        clear_stats();
        send_frame(8'h81, 1'b1, 1, 4);
        hold(20);
        chk("rst_frame_count", rxq.size(), 0);
        chk("rst_frame_ferr", ferr_cnt, 0);
        chk("rst_frame_ovr", ovr_cnt, 0);
        send_frame(8'h7E, 1'b1, 1, -1);
        hold(4);
        chk("post_rst_count", rxq.size(), 1);
        chk("post_rst_data", rx_at(0), 32'h7E);

        chk("no_simul_pulse", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
